systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Upstream operand stage for the N×N systolic matrix-multiply array.
- Buffers one A matrix (row-wise) and one B matrix (row-wise) through a valid/ready load port.
- On start, it pulses the array's active-high reset, then drives skewed, zero-padded operand wavefronts onto the array's left (A) and top (B) edges.
- Signals done once the last operand has propagated through PE(N-1,N-1).

Parameters:
- N, 4, matrix dimension / array size.
- DATA_W, 8, operand width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  load beat valid.
- load_ready  out  1  feeder can accept a load beat.
- load_sel  in  1  0 = A matrix, 1 = B matrix.
- load_row  in  $clog2(N)  row index written.
- load_data  in  N*DATA_W  row elements; element k at bits [k*DATA_W +: DATA_W].
- start  in  1  begin a multiply using the buffered matrices.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at end of feed.
- arr_rst  out  1  active-high reset to array (clears accumulators and cycle counter).
- a_edge  out  [DATA_W-1:0] x N (unpacked)  left-edge operands, A_in of array.
- b_edge  out  [DATA_W-1:0] x N (unpacked)  top-edge operands, B_in of array.

Behaviour:
- Storage: two N×N register banks, Abuf and Bbuf. Contents persist across runs and are not cleared by start; only rst_n clears them to 0.
- Load transfer: occurs when load_valid && load_ready. It writes load_data into row load_row of the bank selected by load_sel.
  - load_ready = 1 only in IDLE.
  - Rewriting the same row overwrites it; last write wins.
- FSM states: IDLE → CLR → FEED → DONE → IDLE.
  - IDLE: arr_rst = 1, edges = 0. start = 1 → CLR.
  - start and a load beat in the same IDLE cycle: the load is written and start is accepted; the FEED uses the new row.
  - CLR: one cycle; arr_rst = 1; feed counter t = 0; busy = 1. Next → FEED.
  - FEED: arr_rst = 0; lasts exactly 3N-1 cycles (t = 0 .. 3N-2). At t = 3N-2 → DONE.
  - DONE: one cycle; done = 1; arr_rst = 0, so C is held for the consumer. Next → IDLE.
  - The array stays in reset (C cleared) after returning to IDLE, so the consumer must capture C on the done cycle.
- Skew, registered outputs: during the FEED cycle with counter t:
  - a_edge[i] = Abuf[i][t-i] if 0 ≤ t-i < N, else 0.
  - b_edge[j] = Bbuf[t-j][j] if 0 ≤ t-j < N, else 0.
  - Values are registered, so they are valid in the same cycle the array's internal cycle counter reads t. arr_rst deasserts at the FEED entry edge, so array cycle 0 = feeder t 0.
- Idle outputs: outside FEED, all edges = 0.
- start while busy: ignored. No queueing and no restart.
- Reset: rst_n low at any time, including mid-FEED, forces the following:
  - state IDLE, t = 0;
  - busy = 0, done = 0, load_ready = 0 while asserted (1 after release);
  - arr_rst = 1; edges = 0; both banks = 0.
- Counter width: $clog2(3N)+1 bits. The counter saturates logically at the transition; no wrap.

Optional Feature:
- SPARSE_MASK_EN
- Defined:
  - Adds outputs a_nz and b_nz, each N x 1 bit; a_nz[i] = (a_edge[i] != 0), registered alongside the edges.
  - Adds a per-run output skip_cnt, $clog2(2*N*N)+1 bits. It counts non-padding slots whose operand is zero. It is cleared in CLR and valid at done.
  - The array uses these to gate PE enables.
- Undefined: ports are absent; no extra logic.

Test Plan:
- N=4; load A = 1..16 row-major, B = identity; start.
  - → busy next cycle; arr_rst = 1 for exactly one cycle (CLR).
  - 11 FEED cycles; done pulse.
  - Array C equals A on the done cycle.
- FEED t=0 → a_edge = {1,0,0,0}, b_edge = {1,0,0,0}.
- FEED t=3 → a_edge = {4,7,10,13}.
- FEED t=9 → a_edge = {0,0,0,0}.
- Load beat presented while busy → load_ready = 0, bank unchanged. start pulsed mid-FEED → no effect; done occurs once, 13 cycles after original start.
- rst_n asserted at FEED t=5 → immediately arr_rst = 1, edges = 0, busy = 0. After release, start with no reload → all edges 0 throughout (banks cleared).
- SPARSE_MASK_EN, A with row 0 all zero, B = identity → skip_cnt = 16 at done (4 zeros in A + 12 in B); a_nz[0] = 0 throughout.

Source files
------------

// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: matrix load port (valid/ready) between an operand
// source (master) and the systolic feeder (slave).
interface systolic_feeder_if #(
   parameter int N      = 4,
   parameter int DATA_W = 8
);
   logic                   load_valid;
   logic                   load_ready;
   logic                   load_sel;    // 0 = A bank, 1 = B bank
   logic [$clog2(N)-1:0]   load_row;
   logic [N*DATA_W-1:0]    load_data;   // element k at [k*DATA_W +: DATA_W]

   modport master (
      output load_valid, load_sel, load_row, load_data,
      input  load_ready
   );

   modport slave (
      input  load_valid, load_sel, load_row, load_data,
      output load_ready
   );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers one A and one B matrix, then pulses the array
// reset and drives skewed, zero-padded wavefronts onto the left (A) and
// top (B) edges of an N x N systolic array. Signals done once the last
// operand has passed PE(N-1,N-1).
// Optional feature macro SPARSE_MASK_EN: adds per-edge nonzero flags
// (a_nz, b_nz) and a per-run count of zero operands in non-padding slots.
module systolic_feeder #(
   parameter int N      = 4,
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   systolic_feeder_if.slave      ld,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  arr_rst,
   output logic [DATA_W-1:0]     a_edge [N],
   output logic [DATA_W-1:0]     b_edge [N]
`ifdef SPARSE_MASK_EN
   ,
   output logic [N-1:0]          a_nz,
   output logic [N-1:0]          b_nz,
   output logic [$clog2(2*N*N):0] skip_cnt
`endif
);

   localparam int              T_W    = $clog2(3*N) + 1;
   localparam logic [T_W-1:0]  T_LAST = T_W'(3*N - 2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLR,
      S_FEED,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [T_W-1:0]        r_t;
   logic [T_W-1:0]        w_t_nxt;
   logic                  w_feed_nxt;
   logic                  w_load_fire;

   logic [DATA_W-1:0]     r_abuf [N][N];
   logic [DATA_W-1:0]     r_bbuf [N][N];
   logic [DATA_W-1:0]     w_a_nxt [N];
   logic [DATA_W-1:0]     w_b_nxt [N];

   // Loads are only taken in IDLE, and never while the reset is held.
   assign ld.load_ready = rst_n && (r_state == S_IDLE);
   assign w_load_fire   = ld.load_valid && ld.load_ready;

   // State register and feed counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_t     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_t     <= w_t_nxt;
      end
   end

   // Next state, next counter value and state-decoded control outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_t_nxt     = '0;
      busy        = 1'b0;
      done        = 1'b0;
      arr_rst     = 1'b0;
      case (r_state)
         S_IDLE: begin
            arr_rst = 1'b1;
            if (start) w_state_nxt = S_CLR;
         end
         S_CLR: begin
            arr_rst     = 1'b1;
            busy        = 1'b1;
            w_state_nxt = S_FEED;
         end
         S_FEED: begin
            busy = 1'b1;
            if (r_t == T_LAST) w_state_nxt = S_DONE;
            else               w_t_nxt     = r_t + 1'b1;
         end
         S_DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_feed_nxt = (w_state_nxt == S_FEED);
   end

   // Operand banks: cleared only by rst_n, written row-wise by load beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) begin
               r_abuf[r][k] <= '0;
               r_bbuf[r][k] <= '0;
            end
         end
      end else if (w_load_fire) begin
         for (int k = 0; k < N; k++) begin
            if (ld.load_sel) r_bbuf[ld.load_row][k] <= ld.load_data[k*DATA_W +: DATA_W];
            else             r_abuf[ld.load_row][k] <= ld.load_data[k*DATA_W +: DATA_W];
         end
      end
   end

   // Skewed operands for the next cycle's counter value; the edge registers
   // then present slot t in the same cycle the array counts t.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_a_nxt[i] = '0;
         w_b_nxt[i] = '0;
      end
      if (w_feed_nxt) begin
         for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
               if (int'(w_t_nxt) == i + k) begin
                  w_a_nxt[i] = r_abuf[i][k];
                  w_b_nxt[i] = r_bbuf[k][i];
               end
            end
         end
      end
   end

   // Edge registers; zero outside FEED and forced to zero by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            a_edge[i] <= '0;
            b_edge[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            a_edge[i] <= w_a_nxt[i];
            b_edge[i] <= w_b_nxt[i];
         end
      end
   end

`ifdef SPARSE_MASK_EN
   logic [N-1:0]             w_slot;
   logic [$clog2(2*N*N):0]   w_zero_cnt;

   // Zero operands that fall in real (non-padding) slots of the next cycle.
   always_comb begin
      w_zero_cnt = '0;
      for (int i = 0; i < N; i++) begin
         w_slot[i] = w_feed_nxt && (int'(w_t_nxt) >= i) && (int'(w_t_nxt) < i + N);
         if (w_slot[i] && (w_a_nxt[i] == '0)) w_zero_cnt = w_zero_cnt + 1'b1;
         if (w_slot[i] && (w_b_nxt[i] == '0)) w_zero_cnt = w_zero_cnt + 1'b1;
      end
   end

   // Nonzero flags track the edge registers; skip count restarts on each run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_nz     <= '0;
         b_nz     <= '0;
         skip_cnt <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            a_nz[i] <= (w_a_nxt[i] != '0);
            b_nz[i] <= (w_b_nxt[i] != '0);
         end
         if (w_state_nxt == S_CLR) skip_cnt <= '0;
         else if (w_feed_nxt)      skip_cnt <= skip_cnt + w_zero_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed bench for systolic_feeder (N=4, DATA_W=8)
// with a small behavioural systolic array hung off the edges.
module tb_systolic_feeder;
   localparam int N      = 4;
   localparam int DATA_W = 8;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              busy;
   logic              done;
   logic              arr_rst;
   logic [DATA_W-1:0] a_edge [N];
   logic [DATA_W-1:0] b_edge [N];
`ifdef SPARSE_MASK_EN
   logic [N-1:0]      a_nz;
   logic [N-1:0]      b_nz;
   logic [5:0]        skip_cnt;
`endif

   systolic_feeder_if #(.N(N), .DATA_W(DATA_W)) ifc ();

   systolic_feeder #(.N(N), .DATA_W(DATA_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld      (ifc),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .arr_rst (arr_rst),
      .a_edge  (a_edge),
      .b_edge  (b_edge)
`ifdef SPARSE_MASK_EN
      ,
      .a_nz    (a_nz),
      .b_nz    (b_nz),
      .skip_cnt(skip_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural output-stationary array: A moves right, B moves down.
   logic [31:0]       c_m [N][N];
   logic [DATA_W-1:0] ar  [N][N];
   logic [DATA_W-1:0] br  [N][N];

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            logic [DATA_W-1:0] av;
            logic [DATA_W-1:0] bv;
            av = (j == 0) ? a_edge[i] : ar[i][(j > 0) ? j - 1 : 0];
            bv = (i == 0) ? b_edge[j] : br[(i > 0) ? i - 1 : 0][j];
            if (arr_rst) begin
               c_m[i][j] <= '0;
               ar[i][j]  <= '0;
               br[i][j]  <= '0;
            end else begin
               c_m[i][j] <= c_m[i][j] + 32'(av) * 32'(bv);
               ar[i][j]  <= av;
               br[i][j]  <= bv;
            end
         end
      end
   end

   logic [DATA_W-1:0] ma [N][N];
   logic [DATA_W-1:0] mb [N][N];
   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pk_a();
      return {a_edge[3], a_edge[2], a_edge[1], a_edge[0]};
   endfunction

   function automatic logic [31:0] pk_b();
      return {b_edge[3], b_edge[2], b_edge[1], b_edge[0]};
   endfunction

   function automatic logic [31:0] exp_a(input int t);
      logic [31:0] v = '0;
      for (int i = 0; i < N; i++)
         if (t - i >= 0 && t - i < N) v[i*8 +: 8] = ma[i][t-i];
      return v;
   endfunction

   function automatic logic [31:0] exp_b(input int t);
      logic [31:0] v = '0;
      for (int j = 0; j < N; j++)
         if (t - j >= 0 && t - j < N) v[j*8 +: 8] = mb[t-j][j];
      return v;
   endfunction

   function automatic logic [3:0] nz4(input logic [31:0] v);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (v[i*8 +: 8] != 8'd0);
      return r;
   endfunction

   function automatic logic [31:0] row_data(input logic sel, input int r);
      logic [31:0] v;
      for (int k = 0; k < N; k++) v[k*8 +: 8] = sel ? mb[r][k] : ma[r][k];
      return v;
   endfunction

   task automatic load_beat(input logic sel, input int r, input logic [31:0] d);
      ifc.load_valid = 1'b1;
      ifc.load_sel   = sel;
      ifc.load_row   = 2'(r);
      ifc.load_data  = d;
      step();
      ifc.load_valid = 1'b0;
   endtask

   task automatic load_all();
      for (int r = 0; r < N; r++) load_beat(1'b0, r, row_data(1'b0, r));
      for (int r = 0; r < N; r++) load_beat(1'b1, r, row_data(1'b1, r));
   endtask

   task automatic check_c();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            check_eq("c_equals_a", c_m[i][j], 32'(ma[i][j]));
   endtask

   initial begin
      rst_n          = 1'b0;
      start          = 1'b0;
      ifc.load_valid = 1'b0;
      ifc.load_sel   = 1'b0;
      ifc.load_row   = '0;
      ifc.load_data  = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ma[i][j] = 8'(i * N + j + 1);
            mb[i][j] = (i == j) ? 8'd1 : 8'd0;
         end

      // Reset state
      step();
      check_eq("rst_ctl", {busy, done, arr_rst, ifc.load_ready}, 4'b0010);
      check_eq("rst_edges", pk_a() | pk_b(), 32'h0);
      step();
      rst_n = 1'b1;
      #1;
      check_eq("ready_after_rst", ifc.load_ready, 1'b1);

      // Run 1: A = 1..16, B = identity; A row 3 first loaded as zeros and
      // replaced by a beat in the start cycle.
      for (int r = 0; r < 3; r++) load_beat(1'b0, r, row_data(1'b0, r));
      load_beat(1'b0, 3, 32'h0);
      for (int r = 0; r < N; r++) load_beat(1'b1, r, row_data(1'b1, r));
      start          = 1'b1;
      ifc.load_valid = 1'b1;
      ifc.load_sel   = 1'b0;
      ifc.load_row   = 2'd3;
      ifc.load_data  = row_data(1'b0, 3);
      step();
      start          = 1'b0;
      ifc.load_valid = 1'b0;
      check_eq("clr_ctl", {busy, done, arr_rst, ifc.load_ready}, 4'b1010);
      step();
      check_eq("a_t0_hand", pk_a(), 32'h00000001);
      check_eq("b_t0_hand", pk_b(), 32'h00000001);
      for (int t = 0; t <= 10; t++) begin
         check_eq("a_edge", pk_a(), exp_a(t));
         check_eq("b_edge", pk_b(), exp_b(t));
         check_eq("feed_ctl", {busy, done, arr_rst}, 3'b100);
`ifdef SPARSE_MASK_EN
         check_eq("a_nz", a_nz, nz4(exp_a(t)));
         check_eq("b_nz", b_nz, nz4(exp_b(t)));
`endif
         if (t == 3) check_eq("a_t3_hand", pk_a(), 32'h0D0A0704);
         if (t == 9) check_eq("a_t9_hand", pk_a(), 32'h0);
         if (t == 1) begin
            ifc.load_valid = 1'b1;
            ifc.load_sel   = 1'b0;
            ifc.load_row   = 2'd0;
            ifc.load_data  = 32'hFFFFFFFF;
            #1;
            check_eq("ready_busy", ifc.load_ready, 1'b0);
         end
         if (t == 2) begin
            ifc.load_valid = 1'b0;
            start          = 1'b1;
         end
         if (t == 3) start = 1'b0;
         step();
      end
      check_eq("done_ctl", {busy, done, arr_rst}, 3'b110);
      check_c();
`ifdef SPARSE_MASK_EN
      check_eq("skip_run1", skip_cnt, 6'd12);
`endif
      for (int k = 0; k < 4; k++) begin
         step();
         check_eq("idle_ctl", {busy, done, arr_rst, ifc.load_ready}, 4'b0011);
      end

      // Run 2: reset asserted at FEED t=5.
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 6; k++) step();
      check_eq("a_t5_pre", pk_a(), exp_a(5));
      rst_n = 1'b0;
      #1;
      check_eq("midrst_ctl", {busy, done, arr_rst, ifc.load_ready}, 4'b0010);
      check_eq("midrst_edges", pk_a() | pk_b(), 32'h0);
      step();
      rst_n = 1'b1;
      #1;

      // Run 3: no reload; banks were cleared, so every edge stays zero.
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      for (int t = 0; t <= 10; t++) begin
         check_eq("cleared_edges", pk_a() | pk_b(), 32'h0);
         step();
      end
      check_eq("done_run3", done, 1'b1);

`ifdef SPARSE_MASK_EN
      // Run 4: A row 0 all zero, B = identity.
      for (int k = 0; k < N; k++) ma[0][k] = 8'd0;
      load_all();
      start = 1'b1;
      step();
      start = 1'b0;
      check_eq("skip_clr", skip_cnt, 6'd0);
      step();
      for (int t = 0; t <= 10; t++) begin
         check_eq("a_nz0_zero", a_nz[0], 1'b0);
         check_eq("a_nz_sp", a_nz, nz4(exp_a(t)));
         check_eq("a_edge_sp", pk_a(), exp_a(t));
         step();
      end
      check_eq("done_sp", done, 1'b1);
      check_eq("skip_run4", skip_cnt, 6'd16);
      check_c();
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
